// File: rtl/udp_tx_arbiter_if.sv
// AXI-stream bundle for the UDP transmit arbiter: one frame source or the shared sink.
// tuser carries UDP header/metadata and is never interpreted here.
interface udp_tx_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned USER_W = 64,
  parameter int unsigned KEEP_W = 4
) ();

  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tready;

  modport master (
    output tvalid,
    output tdata,
    output tuser,
    output tkeep,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tuser,
    input  tkeep,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/udp_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one UDP TX AXI-stream between two sources.
// Define UDP_TX_ARB_STALL_TIMEOUT_EN to abort frames whose source stalls for TIMEOUT cycles.
module udp_tx_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned USER_W  = 64,
  parameter int unsigned KEEP_W  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              sclk,
  input  logic              reset,
  udp_tx_arbiter_if.slave   s0,
  udp_tx_arbiter_if.slave   s1,
  udp_tx_arbiter_if.master  m,
  output logic [1:0]        grant,
  output logic [15:0]       frame_cnt0,
  output logic [15:0]       frame_cnt1,
  output logic              abort_pulse
);

  typedef enum logic [1:0] {StIdle, StBusy, StAbort, StDrain} state_e;

  state_e      state_q;
  logic [1:0]  grant_q;
  logic        rr_last_q;
  logic [15:0] frame_cnt0_q;
  logic [15:0] frame_cnt1_q;

  // Selected source: index of the current owner (only meaningful while granted).
  logic              sel;
  logic              sg_tvalid;
  logic [DATA_W-1:0] sg_tdata;
  logic [USER_W-1:0] sg_tuser;
  logic [KEEP_W-1:0] sg_tkeep;
  logic              sg_tlast;

  logic              out_tvalid;
  logic [DATA_W-1:0] out_tdata;
  logic [USER_W-1:0] out_tuser;
  logic [KEEP_W-1:0] out_tkeep;
  logic              out_tlast;
  logic              ready0;
  logic              ready1;

  logic req_any;
  logic pick;

  assign sel = grant_q[1];

  always_comb begin
    sg_tvalid = sel ? s1.tvalid : s0.tvalid;
    sg_tdata  = sel ? s1.tdata  : s0.tdata;
    sg_tuser  = sel ? s1.tuser  : s0.tuser;
    sg_tkeep  = sel ? s1.tkeep  : s0.tkeep;
    sg_tlast  = sel ? s1.tlast  : s0.tlast;
  end

  // On contention the port that did not send the previous frame wins.
  assign req_any = s0.tvalid | s1.tvalid;
  assign pick    = (s0.tvalid & s1.tvalid) ? ~rr_last_q : s1.tvalid;

`ifdef UDP_TX_ARB_STALL_TIMEOUT_EN
  localparam logic [15:0] TimeoutM1 = 16'(TIMEOUT - 1);

  logic [15:0]       stall_cnt_q;
  logic [USER_W-1:0] user_q;
  logic              abort_pulse_q;

  assign abort_pulse = abort_pulse_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign abort_pulse    = 1'b0;
`endif

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      grant_q       <= 2'b00;
      rr_last_q     <= 1'b1;
      frame_cnt0_q  <= 16'h0000;
      frame_cnt1_q  <= 16'h0000;
`ifdef UDP_TX_ARB_STALL_TIMEOUT_EN
      stall_cnt_q   <= 16'h0000;
      user_q        <= '0;
      abort_pulse_q <= 1'b0;
`endif
    end else begin
`ifdef UDP_TX_ARB_STALL_TIMEOUT_EN
      abort_pulse_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (req_any) begin
            grant_q <= pick ? 2'b10 : 2'b01;
            state_q <= StBusy;
`ifdef UDP_TX_ARB_STALL_TIMEOUT_EN
            stall_cnt_q <= 16'h0000;
            // First beat is on the bus now; its tuser is reused for an abort beat.
            user_q      <= pick ? s1.tuser : s0.tuser;
`endif
          end
        end
        StBusy: begin
          if (sg_tvalid && m.tready && sg_tlast) begin
            rr_last_q <= sel;
            if (sel) frame_cnt1_q <= frame_cnt1_q + 16'd1;
            else     frame_cnt0_q <= frame_cnt0_q + 16'd1;
            grant_q <= 2'b00;
            state_q <= StIdle;
          end
`ifdef UDP_TX_ARB_STALL_TIMEOUT_EN
          else if (sg_tvalid) begin
            stall_cnt_q <= 16'h0000;
          end else begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
            if (stall_cnt_q == TimeoutM1) state_q <= StAbort;
          end
`endif
        end
`ifdef UDP_TX_ARB_STALL_TIMEOUT_EN
        StAbort: begin
          if (m.tready) begin
            abort_pulse_q <= 1'b1;
            state_q       <= StDrain;
          end
        end
        StDrain: begin
          if (sg_tvalid && sg_tlast) begin
            rr_last_q <= sel;
            grant_q   <= 2'b00;
            state_q   <= StIdle;
          end
        end
`endif
        default: begin
          grant_q <= 2'b00;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tuser  = '0;
    out_tkeep  = '0;
    out_tlast  = 1'b0;
    ready0     = 1'b0;
    ready1     = 1'b0;
    unique case (state_q)
      StBusy: begin
        out_tvalid = sg_tvalid;
        out_tdata  = sg_tdata;
        out_tuser  = sg_tuser;
        out_tkeep  = sg_tkeep;
        out_tlast  = sg_tlast;
        ready0     = ~sel & m.tready;
        ready1     = sel & m.tready;
      end
`ifdef UDP_TX_ARB_STALL_TIMEOUT_EN
      StAbort: begin
        // Synthetic closing beat: empty keep tells the receiver the frame was cut.
        out_tvalid = 1'b1;
        out_tlast  = 1'b1;
        out_tuser  = user_q;
      end
      StDrain: begin
        ready0 = ~sel;
        ready1 = sel;
      end
`endif
      default: ;
    endcase
  end

  assign m.tvalid  = out_tvalid;
  assign m.tdata   = out_tdata;
  assign m.tuser   = out_tuser;
  assign m.tkeep   = out_tkeep;
  assign m.tlast   = out_tlast;
  assign s0.tready = ready0;
  assign s1.tready = ready1;

  assign grant      = grant_q;
  assign frame_cnt0 = frame_cnt0_q;
  assign frame_cnt1 = frame_cnt1_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: expected beats are queued per scenario and
// matched against every output handshake.
`timescale 1ns/1ps
module tb_udp_tx_arbiter;

`ifdef UDP_TX_ARB_STALL_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 16;
`else
  localparam int unsigned TB_TIMEOUT = 1024;
`endif

  // {tlast, tkeep, tdata, tuser}
  typedef logic [100:0] beat_t;

  logic        sclk  = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  grant;
  logic [15:0] frame_cnt0;
  logic [15:0] frame_cnt1;
  logic        abort_pulse;

  udp_tx_arbiter_if s0_if ();
  udp_tx_arbiter_if s1_if ();
  udp_tx_arbiter_if m_if ();

  udp_tx_arbiter #(
    .DATA_W  (32),
    .USER_W  (64),
    .KEEP_W  (4),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .sclk        (sclk),
    .reset       (reset),
    .s0          (s0_if),
    .s1          (s1_if),
    .m           (m_if),
    .grant       (grant),
    .frame_cnt0  (frame_cnt0),
    .frame_cnt1  (frame_cnt1),
    .abort_pulse (abort_pulse)
  );

  always #5 sclk = ~sclk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  beat_t      exp_q[$];
  int         beat_cyc[$];
  logic [1:0] grant_log[$];
  logic [1:0] prev_grant = 2'b00;

  function automatic beat_t make_beat(int port, int fid, int b, int nbeats, bit with_last);
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
    logic [63:0] user;
    last = with_last && (b == nbeats - 1);
    keep = last ? 4'h7 : 4'hF;
    data = {8'(8'hC0 + port), 8'(fid), 16'(b)};
    user = {32'(fid) ^ 32'h1234_0000, 32'h5500_0000 | 32'(port)};
    return {last, keep, data, user};
  endfunction

  // Scoreboard: every output handshake pops the oldest expected beat.
  always @(negedge sclk) begin
    beat_t got;
    beat_t exp;
    cyc++;
    #2;
    if (m_if.tvalid && m_if.tready) begin
      got = {m_if.tlast, m_if.tkeep, m_if.tdata, m_if.tuser};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard unexpected beat: got %h, required no beat", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL scoreboard beat: got %h, required %h", got, exp);
        else n_pass++;
      end
      beat_cyc.push_back(cyc);
    end
    if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
    prev_grant = grant;
  end

  task automatic drive_src(input int port, input logic valid, input beat_t bt);
    if (port == 0) begin
      s0_if.tvalid = valid;
      {s0_if.tlast, s0_if.tkeep, s0_if.tdata, s0_if.tuser} = bt;
    end else begin
      s1_if.tvalid = valid;
      {s1_if.tlast, s1_if.tkeep, s1_if.tdata, s1_if.tuser} = bt;
    end
  endtask

  // Sends nframes back-to-back frames; tvalid stays high until the last beat is taken.
  task automatic send_frames(input int port, input int fid0, input int nframes,
                             input int nbeats, input bit with_last);
    logic acc;
    int   waitc;
    @(negedge sclk);
    for (int f = 0; f < nframes; f++) begin
      for (int b = 0; b < nbeats; b++) begin
        drive_src(port, 1'b1, make_beat(port, fid0 + f, b, nbeats, with_last));
        waitc = 0;
        forever begin
          #1;
          acc = (port == 0) ? s0_if.tready : s1_if.tready;
          @(negedge sclk);
          if (acc) break;
          waitc++;
          if (waitc > 300) begin
            n_checks++;
            $display("FAIL handshake timeout port %0d: tready got 0, required 1", port);
            drive_src(port, 1'b0, '0);
            return;
          end
        end
      end
    end
    drive_src(port, 1'b0, '0);
  endtask

  task automatic reset_dut;
    drive_src(0, 1'b0, '0);
    drive_src(1, 1'b0, '0);
    m_if.tready = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge sclk);
    reset = 1'b1;
    @(negedge sclk);
    exp_q.delete();
    beat_cyc.delete();
    grant_log.delete();
  endtask

  task automatic test_reset;
    m_if.tready = 1'b1;
    drive_src(0, 1'b1, make_beat(0, 99, 0, 1, 1));
    drive_src(1, 1'b1, make_beat(1, 98, 0, 1, 1));
    #3 reset = 1'b0;
    #2;
    n_checks++; if (grant !== 2'b00) $display("FAIL reset grant: got %b, required 00", grant); else n_pass++;
    n_checks++; if (m_if.tvalid !== 1'b0) $display("FAIL reset m_tvalid: got %b, required 0", m_if.tvalid); else n_pass++;
    n_checks++; if (m_if.tdata !== 32'h0) $display("FAIL reset m_tdata: got %h, required 0", m_if.tdata); else n_pass++;
    n_checks++; if (s0_if.tready !== 1'b0) $display("FAIL reset s0_tready: got %b, required 0", s0_if.tready); else n_pass++;
    n_checks++; if (s1_if.tready !== 1'b0) $display("FAIL reset s1_tready: got %b, required 0", s1_if.tready); else n_pass++;
    n_checks++; if (frame_cnt0 !== 16'h0) $display("FAIL reset frame_cnt0: got %h, required 0", frame_cnt0); else n_pass++;
    n_checks++; if (frame_cnt1 !== 16'h0) $display("FAIL reset frame_cnt1: got %h, required 0", frame_cnt1); else n_pass++;
    n_checks++; if (abort_pulse !== 1'b0) $display("FAIL reset abort_pulse: got %b, required 0", abort_pulse); else n_pass++;
    repeat (2) @(negedge sclk);
    #2;
    n_checks++; if (grant !== 2'b00) $display("FAIL reset held grant: got %b, required 00", grant); else n_pass++;
    reset_dut();
  endtask

  task automatic test_single_source;
    reset_dut();
    for (int b = 0; b < 4; b++) exp_q.push_back(make_beat(0, 1, b, 4, 1));
    fork
      send_frames(0, 1, 1, 4, 1);
      begin
        @(negedge sclk); #2;
        n_checks++; if (grant !== 2'b00) $display("FAIL single grant latency: got %b, required 00", grant); else n_pass++;
        @(negedge sclk); #2;
        n_checks++; if (grant !== 2'b01) $display("FAIL single grant: got %b, required 01", grant); else n_pass++;
      end
    join
    #2;
    n_checks++; if (grant !== 2'b00) $display("FAIL single grant release: got %b, required 00", grant); else n_pass++;
    n_checks++; if (frame_cnt0 !== 16'd1) $display("FAIL single frame_cnt0: got %0d, required 1", frame_cnt0); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL single beats missing: got %0d left, required 0", exp_q.size()); else n_pass++;
    n_checks++;
    if (beat_cyc.size() != 4 || beat_cyc[3] - beat_cyc[0] != 3)
      $display("FAIL single beat spacing: got %0d beats, required 4 in 4 cycles", beat_cyc.size());
    else n_pass++;
  endtask

  task automatic test_contention;
    reset_dut();
    for (int b = 0; b < 3; b++) exp_q.push_back(make_beat(0, 2, b, 3, 1));
    for (int b = 0; b < 3; b++) exp_q.push_back(make_beat(1, 3, b, 3, 1));
    fork
      send_frames(0, 2, 1, 3, 1);
      send_frames(1, 3, 1, 3, 1);
    join
    #2;
    n_checks++; if (frame_cnt0 !== 16'd1) $display("FAIL contention frame_cnt0: got %0d, required 1", frame_cnt0); else n_pass++;
    n_checks++; if (frame_cnt1 !== 16'd1) $display("FAIL contention frame_cnt1: got %0d, required 1", frame_cnt1); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL contention beats missing: got %0d left, required 0", exp_q.size()); else n_pass++;
    n_checks++;
    if (beat_cyc.size() != 6 || beat_cyc[3] - beat_cyc[2] != 2)
      $display("FAIL contention idle bubble: got %0d beats, required 6 with one idle cycle", beat_cyc.size());
    else n_pass++;
  endtask

  task automatic test_fairness;
    logic [1:0] want;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 2; b++) exp_q.push_back(make_beat(0, 20 + i, b, 2, 1));
      for (int b = 0; b < 2; b++) exp_q.push_back(make_beat(1, 30 + i, b, 2, 1));
    end
    fork
      send_frames(0, 20, 4, 2, 1);
      send_frames(1, 30, 4, 2, 1);
    join
    #2;
    n_checks++; if (grant_log.size() != 8) $display("FAIL fairness grant count: got %0d, required 8", grant_log.size()); else n_pass++;
    for (int i = 0; i < grant_log.size() && i < 8; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if (grant_log[i] !== want) $display("FAIL fairness grant order %0d: got %b, required %b", i, grant_log[i], want);
      else n_pass++;
    end
    n_checks++; if (frame_cnt0 !== 16'd4) $display("FAIL fairness frame_cnt0: got %0d, required 4", frame_cnt0); else n_pass++;
    n_checks++; if (frame_cnt1 !== 16'd4) $display("FAIL fairness frame_cnt1: got %0d, required 4", frame_cnt1); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL fairness beats missing: got %0d left, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_pressure;
    bit bp_done;
    reset_dut();
    bp_done = 1'b0;
    for (int b = 0; b < 5; b++) exp_q.push_back(make_beat(1, 40, b, 5, 1));
    fork
      begin
        send_frames(1, 40, 1, 5, 1);
        bp_done = 1'b1;
      end
      while (!bp_done) begin
        @(negedge sclk);
        if (!bp_done) begin
          m_if.tready = ~m_if.tready;
          #2;
          if (grant == 2'b10) begin
            n_checks++;
            if (s1_if.tready !== m_if.tready)
              $display("FAIL backpressure s1_tready: got %b, required %b", s1_if.tready, m_if.tready);
            else n_pass++;
            n_checks++;
            if (s0_if.tready !== 1'b0) $display("FAIL backpressure s0_tready: got %b, required 0", s0_if.tready);
            else n_pass++;
          end
        end
      end
    join
    m_if.tready = 1'b1;
    #2;
    n_checks++; if (frame_cnt1 !== 16'd1) $display("FAIL backpressure frame_cnt1: got %0d, required 1", frame_cnt1); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL backpressure beats missing: got %0d left, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_counter_wrap;
    reset_dut();
    @(negedge sclk);
    force dut.frame_cnt0_q = 16'hFFFF;
    @(negedge sclk);
    release dut.frame_cnt0_q;
    #2;
    n_checks++; if (frame_cnt0 !== 16'hFFFF) $display("FAIL wrap preload: got %h, required FFFF", frame_cnt0); else n_pass++;
    exp_q.push_back(make_beat(0, 50, 0, 1, 1));
    send_frames(0, 50, 1, 1, 1);
    #2;
    n_checks++; if (frame_cnt0 !== 16'h0000) $display("FAIL wrap frame_cnt0: got %h, required 0000", frame_cnt0); else n_pass++;
    n_checks++; if (frame_cnt1 !== 16'h0000) $display("FAIL wrap frame_cnt1: got %h, required 0000", frame_cnt1); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL wrap beat missing: got %0d left, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_async_reset;
    reset_dut();
    exp_q.push_back(make_beat(0, 60, 0, 4, 1));
    @(negedge sclk);
    drive_src(0, 1'b1, make_beat(0, 60, 0, 4, 1));
    @(negedge sclk); #2;
    n_checks++; if (m_if.tvalid !== 1'b1) $display("FAIL midreset pre m_tvalid: got %b, required 1", m_if.tvalid); else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_checks++; if (m_if.tvalid !== 1'b0) $display("FAIL midreset m_tvalid: got %b, required 0", m_if.tvalid); else n_pass++;
    n_checks++; if (grant !== 2'b00) $display("FAIL midreset grant: got %b, required 00", grant); else n_pass++;
    n_checks++; if (s0_if.tready !== 1'b0) $display("FAIL midreset s0_tready: got %b, required 0", s0_if.tready); else n_pass++;
    drive_src(0, 1'b0, '0);
    @(negedge sclk);
    reset = 1'b1;
    @(negedge sclk);
  endtask

`ifdef UDP_TX_ARB_STALL_TIMEOUT_EN
  task automatic test_stall_timeout;
    beat_t first;
    int    c;
    reset_dut();
    first = make_beat(0, 70, 0, 2, 0);
    exp_q.push_back(first);
    exp_q.push_back(make_beat(0, 70, 1, 2, 0));
    exp_q.push_back({1'b1, 4'h0, 32'h0, first[63:0]});
    send_frames(0, 70, 1, 2, 0);
    c = 0;
    #2;
    while (!m_if.tvalid && c < 100) begin
      c++;
      @(negedge sclk); #2;
    end
    n_checks++; if (c != 16) $display("FAIL timeout stall cycles: got %0d, required 16", c); else n_pass++;
    n_checks++; if (m_if.tkeep !== 4'h0) $display("FAIL timeout tkeep: got %h, required 0", m_if.tkeep); else n_pass++;
    @(negedge sclk); #2;
    n_checks++; if (abort_pulse !== 1'b1) $display("FAIL timeout abort_pulse: got %b, required 1", abort_pulse); else n_pass++;
    @(negedge sclk); #2;
    n_checks++; if (abort_pulse !== 1'b0) $display("FAIL timeout abort_pulse width: got %b, required 0", abort_pulse); else n_pass++;
    for (int b = 0; b < 3; b++) begin
      @(negedge sclk);
      drive_src(0, 1'b1, make_beat(0, 71, b, 3, 1));
      #2;
      n_checks++; if (s0_if.tready !== 1'b1) $display("FAIL drain s0_tready: got %b, required 1", s0_if.tready); else n_pass++;
      n_checks++; if (m_if.tvalid !== 1'b0) $display("FAIL drain m_tvalid: got %b, required 0", m_if.tvalid); else n_pass++;
    end
    @(negedge sclk);
    drive_src(0, 1'b0, '0);
    #2;
    n_checks++; if (grant !== 2'b00) $display("FAIL drain grant: got %b, required 00", grant); else n_pass++;
    n_checks++; if (frame_cnt0 !== 16'd0) $display("FAIL timeout frame_cnt0: got %0d, required 0", frame_cnt0); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL timeout beats missing: got %0d left, required 0", exp_q.size()); else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    m_if.tready = 1'b1;
    drive_src(0, 1'b0, '0);
    drive_src(1, 1'b0, '0);
    test_reset();
    test_single_source();
    test_contention();
    test_fairness();
    test_back_pressure();
    test_counter_wrap();
    test_async_reset();
`ifdef UDP_TX_ARB_STALL_TIMEOUT_EN
    test_stall_timeout();
`endif
    repeat (2) @(negedge sclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
